scn_rom_responder: RTL and testbench

SCN_ROM_RESPONDER -- requirements
Module: scn_rom_responder

---
 rtl/scn_rom_responder_pkg.sv | 21 ++
 rtl/scn_rom_responder.sv | 142 ++++++++++++++
 tb/tb_scn_rom_responder.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scn_rom_responder_pkg.sv
// Shared definitions for the ROM responder: FSM encoding and the longword/word
// address widths used between the client side and the 16-bit memory side.
package scn_rom_responder_pkg;

  localparam int LW_ADDR_W = 19;
  localparam int WD_ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    DONE  = 2'd3
  } rom_state_e;

  // Word address of one half of a longword; concatenation only, never a carry.
  function automatic logic [WD_ADDR_W-1:0] word_addr(input logic [LW_ADDR_W-1:0] lw_addr,
                                                     input logic hi_half);
    return {lw_addr, hi_half};
  endfunction

endpackage

// File: rtl/scn_rom_responder.sv
// Toggle-handshake ROM responder: turns a client longword read into two 16-bit
// memory reads, with an optional one-entry last-address hit buffer.
//
// Handshakes:
//   client: a request is outstanding while rom_req != rom_ack; rom_ack is set to
//           the rom_req value sampled at accept, and rom_data is valid whenever
//           rom_ack == rom_req.
//   memory: mem_req is held high with a stable mem_addr until a one-cycle
//           mem_ack, whose mem_data is taken in that same cycle; mem_ack while
//           mem_req is low carries no meaning and is dropped.
module scn_rom_responder
  import scn_rom_responder_pkg::*;
#(
  parameter int HIT_EN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [20:0] rom_address,
  input  logic        rom_req,
  output logic        rom_ack,
  output logic [31:0] rom_data,
  output logic [19:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  rom_state_e             state_q, state_d;
  logic [LW_ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                   req_tog_q, req_tog_d;
  logic                   rom_ack_q, rom_ack_d;
  logic [31:0]            rom_data_q, rom_data_d;
  logic [31:0]            fetch_q, fetch_d;
  logic                   mem_req_q, mem_req_d;
  logic [WD_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LW_ADDR_W-1:0]   hit_addr_q, hit_addr_d;
  logic                   hit_valid_q, hit_valid_d;

  logic                   accept;
  logic                   hit;
  logic                   mem_beat;
  logic                   unused_byte_bits;

  assign unused_byte_bits = ^rom_address[1:0];

  assign accept   = (rom_req != rom_ack_q);
  assign hit      = (HIT_EN != 0) && hit_valid_q && (rom_address[20:2] == hit_addr_q);
  assign mem_beat = mem_req_q & mem_ack;

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_tog_d   = req_tog_q;
    rom_ack_d   = rom_ack_q;
    rom_data_d  = rom_data_q;
    fetch_d     = fetch_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    hit_addr_d  = hit_addr_q;
    hit_valid_d = hit_valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          req_addr_d = rom_address[20:2];
          req_tog_d  = rom_req;
          if (hit) begin
            state_d = DONE;
          end else begin
            state_d    = RD_LO;
            mem_req_d  = 1'b1;
            mem_addr_d = word_addr(rom_address[20:2], 1'b0);
          end
        end
      end
      RD_LO: begin
        if (mem_beat) begin
          fetch_d[15:0] = mem_data;
          mem_addr_d    = word_addr(req_addr_q, 1'b1);
          state_d       = RD_HI;
        end
      end
      RD_HI: begin
        if (mem_beat) begin
          fetch_d[31:16] = mem_data;
          mem_req_d      = 1'b0;
          state_d        = DONE;
        end
      end
      DONE: begin
        // rom_data is republished from the fetch buffer here, so a hit returns
        // the previous longword unchanged and a new fetch never disturbs the
        // data the client is still reading.
        rom_ack_d   = req_tog_q;
        rom_data_d  = fetch_q;
        hit_addr_d  = req_addr_q;
        hit_valid_d = (HIT_EN != 0);
        state_d     = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_tog_q   <= 1'b0;
      rom_ack_q   <= 1'b0;
      rom_data_q  <= '0;
      fetch_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      hit_addr_q  <= '0;
      hit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_tog_q   <= req_tog_d;
      rom_ack_q   <= rom_ack_d;
      rom_data_q  <= rom_data_d;
      fetch_q     <= fetch_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      hit_addr_q  <= hit_addr_d;
      hit_valid_q <= hit_valid_d;
    end
  end

  assign rom_ack   = rom_ack_q;
  assign rom_data  = rom_data_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_scn_rom_responder.sv
// Bench for scn_rom_responder: one instance with the hit buffer, one without,
// sharing a memory responder model and a data/address scoreboard.
module tb_scn_rom_responder;
  import scn_rom_responder_pkg::*;

  localparam int MEM_WAIT = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [20:0] rom_address;
  logic        rom_req_h, rom_req_n;
  logic        rom_ack_h, rom_ack_n;
  logic [31:0] rom_data_h, rom_data_n;
  logic [19:0] mem_addr_h, mem_addr_n;
  logic        mem_req_h, mem_req_n;
  logic        busy_h, busy_n;
  logic [1:0]  dbg_h, dbg_n;
  logic        mem_ack, mem_ack_h, mem_ack_n;
  logic [15:0] mem_data;
  logic        sel;
  logic        stray_req;

  logic        cur_mem_req, cur_rom_ack;
  logic [19:0] cur_mem_addr;
  logic [1:0]  cur_dbg;

  assign mem_ack_h    = mem_ack & ~sel;
  assign mem_ack_n    = mem_ack & sel;
  assign cur_mem_req  = sel ? mem_req_n  : mem_req_h;
  assign cur_mem_addr = sel ? mem_addr_n : mem_addr_h;
  assign cur_rom_ack  = sel ? rom_ack_n  : rom_ack_h;
  assign cur_dbg      = sel ? dbg_n      : dbg_h;

  scn_rom_responder #(.HIT_EN(1)) dut_h (
    .clk(clk), .reset_n(reset_n), .rom_address(rom_address), .rom_req(rom_req_h),
    .rom_ack(rom_ack_h), .rom_data(rom_data_h), .mem_addr(mem_addr_h), .mem_req(mem_req_h),
    .mem_ack(mem_ack_h), .mem_data(mem_data), .busy(busy_h), .dbg_state(dbg_h)
  );

  scn_rom_responder #(.HIT_EN(0)) dut_n (
    .clk(clk), .reset_n(reset_n), .rom_address(rom_address), .rom_req(rom_req_n),
    .rom_ack(rom_ack_n), .rom_data(rom_data_n), .mem_addr(mem_addr_n), .mem_req(mem_req_n),
    .mem_ack(mem_ack_n), .mem_data(mem_data), .busy(busy_n), .dbg_state(dbg_n)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  logic [19:0] exp_addr_q[$];
  int total = 0;
  int bad   = 0;
  int beats = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [19:0] a);
    if (a == 20'h00082) return 16'h1234;
    if (a == 20'h00083) return 16'hABCD;
    return a[15:0] ^ {a[19:16], 12'hC3A};
  endfunction

  function automatic logic [31:0] lw_of(input logic [20:0] byte_addr);
    logic [19:0] lo;
    lo = {byte_addr[20:2], 1'b0};
    return {mem_word({byte_addr[20:2], 1'b1}), mem_word(lo)};
  endfunction

  task automatic push_fetch(input logic [20:0] byte_addr);
    exp_addr_q.push_back({byte_addr[20:2], 1'b0});
    exp_addr_q.push_back({byte_addr[20:2], 1'b1});
  endtask

  // memory responder: ack MEM_WAIT cycles after each beat request
  int wait_cnt;
  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!reset_n) begin
        wait_cnt = 0;
      end else if (stray_req) begin
        mem_ack   = 1'b1;
        mem_data  = 16'hDEAD;
        stray_req = 1'b0;
      end else if (cur_mem_req) begin
        wait_cnt++;
        if (wait_cnt == MEM_WAIT) begin
          wait_cnt = 0;
          mem_ack  = 1'b1;
          mem_data = mem_word(cur_mem_addr);
          beats++;
          if (exp_addr_q.size() == 0) check_val("mem_unexpected", 1, 0);
          else check_val("mem_addr", cur_mem_addr, exp_addr_q.pop_front());
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // monitor: every rom_ack toggle publishes one longword
  logic prev_h, prev_n;
  task automatic score(input logic [31:0] d);
    if (exp_q.size() == 0) check_val("ack_unexpected", 1, 0);
    else check_val("rom_data", d, exp_q.pop_front());
  endtask

  initial begin
    prev_h = 1'b0;
    prev_n = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_h = rom_ack_h;
        prev_n = rom_ack_n;
      end else begin
        if (rom_ack_h !== prev_h) begin
          score(rom_data_h);
          prev_h = rom_ack_h;
        end
        if (rom_ack_n !== prev_n) begin
          score(rom_data_n);
          prev_n = rom_ack_n;
        end
      end
    end
  end

  // driver helpers
  task automatic wait_ack(input logic val, input int budget);
    int n;
    n = 0;
    while (cur_rom_ack !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (cur_rom_ack !== val) check_val("ack_timeout", cur_rom_ack, val);
  endtask

  task automatic wait_state(input rom_state_e st, input int budget);
    int n;
    n = 0;
    while (cur_dbg !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (cur_dbg !== st) check_val("state_timeout", cur_dbg, st);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int b;
  logic [31:0] d1, d2;

  initial begin
    reset_n     = 1'b0;
    rom_address = '0;
    rom_req_h   = 1'b0;
    rom_req_n   = 1'b0;
    sel         = 1'b0;
    stray_req   = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ack", rom_ack_h, 0);
    check_val("rst_data", rom_data_h, 0);
    check_val("rst_mreq", mem_req_h, 0);
    check_val("rst_maddr", mem_addr_h, 0);
    check_val("rst_busy", busy_h, 0);
    check_val("rst_state", dbg_h, IDLE);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // miss
    check_val("model_lo", mem_word(20'h00082), 32'h1234);
    rom_address = 21'h000104;
    exp_q.push_back(32'hABCD1234);
    push_fetch(21'h000104);
    @(posedge clk); #1;
    rom_req_h = 1'b1;
    wait_ack(1'b1, 40);
    check_val("miss_data", rom_data_h, 32'hABCD1234);
    check_val("miss_busy", busy_h, 0);
    check_val("miss_mreq", mem_req_h, 0);
    check_val("miss_beats", beats, 2);

    // hit: two clocks, no memory traffic
    b = beats;
    exp_q.push_back(32'hABCD1234);
    @(posedge clk); #1;
    rom_req_h = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("hit_ack_early", rom_ack_h, 1);
    check_val("hit_state", dbg_h, DONE);
    check_val("hit_mreq", mem_req_h, 0);
    @(negedge clk);
    check_val("hit_ack", rom_ack_h, 0);
    check_val("hit_data", rom_data_h, 32'hABCD1234);
    check_val("hit_beats", beats, b);

    // back-to-back with a toggle during RD_HI, second fetch at the top of memory
    b  = beats;
    d1 = lw_of(21'h000200);
    d2 = lw_of(21'h1FFFFC);
    exp_q.push_back(d1);
    exp_q.push_back(d2);
    push_fetch(21'h000200);
    push_fetch(21'h1FFFFC);
    rom_address = 21'h000200;
    @(posedge clk); #1;
    rom_req_h = 1'b1;
    wait_state(RD_HI, 40);
    @(posedge clk); #1;
    rom_address = 21'h1FFFFC;
    rom_req_h   = 1'b0;
    wait_ack(1'b1, 40);
    wait_ack(1'b0, 40);
    check_val("b2b_final", rom_ack_h, rom_req_h);
    check_val("b2b_data", rom_data_h, d2);
    check_val("b2b_beats", beats, b + 4);

    // double toggle during a fetch: one fetch only
    b = beats;
    exp_q.push_back(lw_of(21'h000400));
    push_fetch(21'h000400);
    rom_address = 21'h000400;
    @(posedge clk); #1;
    rom_req_h = 1'b1;
    repeat (2) @(posedge clk);
    #1 rom_req_h = 1'b0;
    @(posedge clk);
    #1 rom_req_h = 1'b1;
    wait_ack(1'b1, 40);
    repeat (4) @(negedge clk);
    check_val("dbl_ack", rom_ack_h, rom_req_h);
    check_val("dbl_busy", busy_h, 0);
    check_val("dbl_beats", beats, b + 2);
    check_val("dbl_state", dbg_h, IDLE);

    // reset during RD_LO, then a stray mem_ack
    b = beats;
    rom_address = 21'h000800;
    @(posedge clk); #1;
    rom_req_h = 1'b0;
    wait_state(RD_LO, 20);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_ack", rom_ack_h, 0);
    check_val("mid_rst_data", rom_data_h, 0);
    check_val("mid_rst_mreq", mem_req_h, 0);
    check_val("mid_rst_maddr", mem_addr_h, 0);
    check_val("mid_rst_busy", busy_h, 0);
    @(posedge clk); #1;
    reset_n   = 1'b1;
    stray_req = 1'b1;
    repeat (5) @(negedge clk);
    check_val("post_rst_ack", rom_ack_h, 0);
    check_val("post_rst_data", rom_data_h, 0);
    check_val("post_rst_busy", busy_h, 0);
    check_val("post_rst_mreq", mem_req_h, 0);
    check_val("post_rst_beats", beats, b);

    // HIT_EN=0: same address twice means two full fetches
    b = beats;
    @(posedge clk); #1;
    sel         = 1'b1;
    rom_address = 21'h000104;
    exp_q.push_back(32'hABCD1234);
    exp_q.push_back(32'hABCD1234);
    push_fetch(21'h000104);
    push_fetch(21'h000104);
    @(posedge clk); #1;
    rom_req_n = 1'b1;
    wait_ack(1'b1, 40);
    @(posedge clk); #1;
    rom_req_n = 1'b0;
    wait_ack(1'b0, 40);
    check_val("nohit_beats", beats, b + 4);
    check_val("nohit_data", rom_data_n, 32'hABCD1234);
    check_val("nohit_busy", busy_n, 0);

    repeat (2) @(negedge clk);
    check_val("exp_q_left", exp_q.size(), 0);
    check_val("exp_addr_left", exp_addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
